// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage in front of the IF/ID register. Owns the
//             PC and drives the instruction-memory request/hit handshake.
//             It buffers a fetched word across downstream stalls and applies
//             branch/jump redirects while a memory request is still
//             outstanding. It stops fetching for good on halt.
//  Ports    : CLK, RST          - rising-edge clock, sync active-high reset
//             iREN, iaddr       - memory read request / word address
//             ihit, iload       - memory response for the current iaddr
//             stall             - downstream cannot accept this cycle
//             redirect(_pc)     - taken branch/jump and its target
//             halt              - stop fetching (only RST exits)
//             valid_out, instr_out, pc4_out - fetched word, its address + 4
//             pc_out            - current PC register
//             fetch_count       - instructions accepted downstream (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             ihit,
    input  logic [31:0]      iload,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic             valid_out,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc4_out,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      c_word_mask = 32'hFFFF_FFFC;
    localparam logic [31:0]      c_pc_init   = PC_INIT & c_word_mask;
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [31:0]      r_pc_q, w_pc_d;
    logic [31:0]      r_buf_q, w_buf_d;
    logic [31:0]      r_tgt_q, w_tgt_d;
    logic             r_halt_pend_q, w_halt_pend_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    logic [31:0] w_redir_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_ren;
    logic        w_valid;
    logic [31:0] w_instr;
    logic        w_accept;

    assign w_redir_tgt = redirect_pc & c_word_mask;
    assign w_pc_plus4  = r_pc_q + 32'd4;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_pc_d        = r_pc_q;
        w_buf_d       = r_buf_q;
        w_tgt_d       = r_tgt_q;
        w_halt_pend_d = r_halt_pend_q;
        w_ren         = 1'b0;
        w_valid       = 1'b0;
        w_instr       = 32'h0;
        w_accept      = 1'b0;

        case (r_state_q)
            ST_FETCH: begin
                w_ren   = 1'b1;
                w_instr = iload;
                // Outputs keep following the hit even when halting; only the
                // state transition and the accept are suppressed by halt.
                w_valid = ihit && !redirect;
                if (halt) begin
                    w_state_d = ST_HALTED;
                end else if (redirect) begin
                    if (ihit) begin
                        w_pc_d = w_redir_tgt;
                    end else begin
                        // Request still outstanding: keep iaddr stable and
                        // remember where to go once it completes.
                        w_tgt_d   = w_redir_tgt;
                        w_state_d = ST_SQUASH;
                    end
                end else if (ihit) begin
                    if (!stall) begin
                        w_pc_d   = w_pc_plus4;
                        w_accept = 1'b1;
                    end else begin
                        w_buf_d   = iload;
                        w_state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                w_instr = r_buf_q;
                w_valid = !redirect;
                if (halt) begin
                    w_state_d = ST_HALTED;
                end else if (redirect) begin
                    w_pc_d    = w_redir_tgt;
                    w_state_d = ST_FETCH;
                end else if (!stall) begin
                    w_pc_d    = w_pc_plus4;
                    w_accept  = 1'b1;
                    w_state_d = ST_FETCH;
                end
            end

            ST_SQUASH: begin
                w_ren = 1'b1;
                // A halt seen while waiting is remembered so that a one-cycle
                // pulse still takes effect once the request drains.
                w_halt_pend_d = r_halt_pend_q || halt;
                if (ihit) begin
                    w_halt_pend_d = 1'b0;
                    if (r_halt_pend_q || halt) begin
                        w_state_d = ST_HALTED;
                    end else begin
                        w_pc_d    = redirect ? w_redir_tgt : r_tgt_q;
                        w_state_d = ST_FETCH;
                    end
                end else if (redirect) begin
                    w_tgt_d = w_redir_tgt;
                end
            end

            default: begin
                // ST_HALTED: everything frozen until reset.
            end
        endcase

        w_cnt_d = w_accept ? (r_cnt_q + c_cnt_one) : r_cnt_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q     <= ST_FETCH;
            r_pc_q        <= c_pc_init;
            r_buf_q       <= 32'h0;
            r_tgt_q       <= 32'h0;
            r_halt_pend_q <= 1'b0;
            r_cnt_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_pc_q        <= w_pc_d;
            r_buf_q       <= w_buf_d;
            r_tgt_q       <= w_tgt_d;
            r_halt_pend_q <= w_halt_pend_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: quiet while reset is held
    // ------------------------------------------------------------------
    assign iREN        = w_ren && !RST;
    assign iaddr       = r_pc_q;
    assign valid_out   = w_valid && !RST;
    assign instr_out   = RST ? 32'h0 : w_instr;
    assign pc4_out     = RST ? 32'h0 : w_pc_plus4;
    assign pc_out      = r_pc_q;
    assign fetch_count = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_unit #(
        .PC_INIT (32'h0000_0000),
        .CNT_W   (32)
    ) u_dut (
        .CLK         (clk),
        .RST         (rst),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .ihit        (ihit),
        .iload       (iload),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .valid_out   (valid_out),
        .instr_out   (instr_out),
        .pc4_out     (pc4_out),
        .pc_out      (pc_out),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge and
    // outputs are checked one further unit later.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ihit = 1'b1; iload = 32'hFFFF_FFFF; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        cyc; cyc;
        #1;
        // ---------------- reset state ----------------
        check_eq("rst_iren",  iREN, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_instr", instr_out, 0);
        check_eq("rst_pc4",   pc4_out, 0);
        check_eq("rst_pc",    pc_out, 0);
        check_eq("rst_cnt",   fetch_count, 0);

        // ---------------- sequential fetch ----------------
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iload = 32'h0000_1000 + k;
            #1;
            check_eq("seq_iren",  iREN, 1);
            check_eq("seq_iaddr", iaddr, 4 * k);
            check_eq("seq_valid", valid_out, 1);
            check_eq("seq_instr", instr_out, 32'h0000_1000 + k);
            check_eq("seq_pc4",   pc4_out, 4 * k + 4);
            cyc;
        end
        #1;
        check_eq("seq_cnt", fetch_count, 4);
        check_eq("seq_pc",  pc_out, 32'h10);

        // ---------------- stall with hold buffer ----------------
        iload = 32'h2008_0005; stall = 1'b1;
        #1;
        check_eq("stl_hit_valid", valid_out, 1);
        check_eq("stl_hit_instr", instr_out, 32'h2008_0005);
        cyc;
        ihit = 1'b0; iload = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("hold_iren",  iREN, 0);
            check_eq("hold_valid", valid_out, 1);
            check_eq("hold_instr", instr_out, 32'h2008_0005);
            check_eq("hold_pc4",   pc4_out, 32'h14);
            check_eq("hold_pc",    pc_out, 32'h10);
            check_eq("hold_cnt",   fetch_count, 4);
            cyc;
        end
        stall = 1'b0;
        #1;
        check_eq("rel_valid", valid_out, 1);
        check_eq("rel_instr", instr_out, 32'h2008_0005);
        cyc;
        #1;
        check_eq("rel_iren",  iREN, 1);
        check_eq("rel_iaddr", iaddr, 32'h14);
        check_eq("rel_cnt",   fetch_count, 5);

        // advance to 0x20: 0x14, 0x18, 0x1C accepted
        ihit = 1'b1;
        cyc; cyc; cyc;
        // ---------------- redirect during outstanding request ----------------
        ihit = 1'b0;
        #1;
        check_eq("sq0_iaddr", iaddr, 32'h20);
        check_eq("sq0_cnt",   fetch_count, 8);
        cyc;
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        check_eq("sq1_valid", valid_out, 0);
        cyc;
        redirect = 1'b0; redirect_pc = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("sq_iren",  iREN, 1);
            check_eq("sq_iaddr", iaddr, 32'h20);
            check_eq("sq_valid", valid_out, 0);
            cyc;
        end
        ihit = 1'b1; iload = 32'h0BAD_0BAD;
        #1;
        check_eq("sq_hit_valid", valid_out, 0);
        check_eq("sq_hit_iaddr", iaddr, 32'h20);
        cyc;
        ihit = 1'b0;
        #1;
        check_eq("sq_new_iaddr", iaddr, 32'h100);
        check_eq("sq_cnt",       fetch_count, 8);

        // ---------------- latest redirect wins ----------------
        redirect = 1'b1; redirect_pc = 32'h300;
        cyc;
        redirect_pc = 32'h200;
        #1;
        check_eq("lw_iaddr", iaddr, 32'h100);
        cyc;
        redirect = 1'b0; redirect_pc = 32'h0; ihit = 1'b1;
        #1;
        check_eq("lw_hit_valid", valid_out, 0);
        cyc;
        ihit = 1'b0;
        #1;
        check_eq("lw_iaddr_new", iaddr, 32'h200);
        check_eq("lw_cnt",       fetch_count, 8);

        // ---------------- PC wrap ----------------
        ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        #1;
        check_eq("wr_redir_valid", valid_out, 0);
        cyc;
        redirect = 1'b0; redirect_pc = 32'h0; iload = 32'h1234_5678;
        #1;
        check_eq("wr_iaddr", iaddr, 32'hFFFF_FFFC);
        check_eq("wr_pc4",   pc4_out, 32'h0);
        check_eq("wr_valid", valid_out, 1);
        cyc;
        #1;
        check_eq("wr_next_iaddr", iaddr, 32'h0);
        check_eq("wr_cnt",        fetch_count, 9);

        // ---------------- halt while holding ----------------
        stall = 1'b1; iload = 32'hCAFE_0001;
        cyc;
        ihit = 1'b0; halt = 1'b1;
        #1;
        check_eq("hh_valid", valid_out, 1);
        cyc;
        halt = 1'b0; stall = 1'b0; ihit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_eq("hlt_iren",  iREN, 0);
            check_eq("hlt_valid", valid_out, 0);
            check_eq("hlt_cnt",   fetch_count, 9);
            check_eq("hlt_pc",    pc_out, 0);
            cyc;
        end
        rst = 1'b1;
        #1;
        check_eq("hr_iren", iREN, 0);
        cyc;
        rst = 1'b0;
        #1;
        check_eq("hr_iren_after",  iREN, 1);
        check_eq("hr_iaddr_after", iaddr, 32'h0);
        check_eq("hr_cnt_after",   fetch_count, 0);

        // ---------------- halt in FETCH with a hit: no accept ----------------
        halt = 1'b1; iload = 32'h0000_00AA;
        #1;
        check_eq("hf_valid", valid_out, 1);
        cyc;
        halt = 1'b0;
        #1;
        check_eq("hf_cnt",  fetch_count, 0);
        check_eq("hf_pc",   pc_out, 0);
        check_eq("hf_iren", iREN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and drives the instruction-memory request/hit handshake.
- Delivers instruction and pc+4 with a valid flag; the hazard logic combines this flag with its stall to form the IF/ID enable.
- Buffers a fetched word when the pipeline stalls, applies branch/jump redirects safely while a memory request is still outstanding, and stops fetching on halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
CNT_W, 32, width of the accepted-instruction counter

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  reset, synchronous, active-high
iREN  out  1  instruction-memory read request
iaddr  out  32  instruction-memory address; bits [1:0] always 0
ihit  in  1  memory returns iload this cycle for the current iaddr
iload  in  32  instruction word from memory
stall  in  1  downstream cannot accept this cycle
redirect  in  1  branch/jump taken; discard the in-flight fetch
redirect_pc  in  32  redirect target; bits [1:0] ignored
halt  in  1  halt seen downstream; stop fetching
valid_out  out  1  instr_out/pc4_out hold a valid instruction
instr_out  out  32  fetched instruction
pc4_out  out  32  address of instr_out + 4
pc_out  out  32  current PC register
fetch_count  out  CNT_W  number of instructions accepted downstream

Behaviour:
- Reset (RST high at a clock edge):
  - PC set to PC_INIT, state set to FETCH, buffer cleared, fetch_count set to 0.
  - While RST is high, iREN=0, valid_out=0, instr_out=0 and pc4_out=0.
  - First cycle after release: iREN=1, iaddr=PC_INIT.
  - Reset mid-request discards the request; the memory must tolerate iREN dropping.
- Acceptance: an instruction is accepted on a cycle where valid_out=1, stall=0 and redirect=0. fetch_count increments on accept and wraps modulo 2^CNT_W.
- All PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Outputs are combinational from state, PC, buffer and inputs. Zero added latency: a hit in FETCH is presented on valid_out in the same cycle.
- State FETCH: iREN=1, iaddr=PC.
  - redirect && ihit: PC <= {redirect_pc[31:2],2'b00}; stay in FETCH; valid_out=0.
  - redirect && !ihit: latch target into tgt; go to SQUASH; valid_out=0.
  - !redirect && ihit: valid_out=1, instr_out=iload, pc4_out=PC+4.
    - if !stall: PC <= PC+4 and stay in FETCH.
    - if stall: buf <= iload, go to HOLD, PC unchanged.
  - !ihit: valid_out=0, keep requesting, PC unchanged (stall irrelevant).
- State HOLD: iREN=0, valid_out=1, instr_out=buf, pc4_out=PC+4.
  - redirect: PC <= target, go to FETCH; the buffered word is dropped (valid_out forced to 0 this cycle).
  - else if !stall: PC <= PC+4, go to FETCH.
  - else stay in HOLD.
- State SQUASH: iREN=1, iaddr=PC (the old address is held stable until the hit), valid_out=0.
  - A new redirect overwrites tgt (latest wins).
  - On ihit: PC <= tgt (or redirect_pc if redirect is high in the same cycle), go to FETCH; the returned word is discarded.
- State HALTED: iREN=0, valid_out=0, PC frozen. Exited only by RST.
- Halt priority:
  - halt=1 in FETCH or HOLD: go to HALTED at the next edge. The current cycle's outputs still follow the state rules, but no accept is counted and the PC is not updated.
  - halt in SQUASH: wait for ihit, then go to HALTED.
- Priority within a cycle: RST > halt > redirect > stall.

Test Plan:
- Reset release with PC_INIT=0, ihit tied 1, stall=0 -> iaddr 0,4,8,C on consecutive cycles; pc4_out 4,8,C,10; fetch_count reaches 4 after 4 cycles.
- Hit at PC=0x10 with iload=0x2008_0005 while stall=1 for 3 cycles -> iREN drops; valid_out=1 with instr_out=0x2008_0005 and pc4_out=0x14 held 3 cycles; on stall release PC becomes 0x14 and iaddr=0x14 with iREN=1 next cycle.
- ihit delayed 4 cycles at PC=0x20, redirect to 0x103 asserted in cycle 1 -> iaddr stays 0x20 until the hit, the hit word is discarded (valid_out=0), next iaddr=0x100, fetch_count unchanged.
- In SQUASH, a second redirect to 0x200 before the hit -> after the hit, iaddr=0x200, not the first target.
- PC=0xFFFF_FFFC, ihit=1, stall=0 -> pc4_out=0, next iaddr=0.
- halt=1 while in HOLD -> next cycle iREN=0, valid_out=0, fetch_count frozen for 10 cycles; RST=1 then 0 -> iaddr=PC_INIT, iREN=1.
